// File: rtl/mul_err_pkg.sv
// Shared types and width helpers for the approximate-multiplier error monitor.
package mul_err_pkg;

  localparam int unsigned DEF_WIDTH   = 6;
  localparam int unsigned DEF_SAMPLES = 4096;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  // Counter width able to hold the value SAMPLES itself.
  function automatic int unsigned cnt_width(input int unsigned samples);
    return $clog2(samples + 1);
  endfunction

  // ED sum width: one product width plus enough headroom for SAMPLES terms.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned samples);
    return 2 * width + cnt_width(samples);
  endfunction

endpackage

// File: rtl/mul_err_monitor_err_dist.sv
// Combinational error distance |exact - approx| on unsigned operands.
module err_dist #(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0] exact,
  input  logic [W-1:0] approx,
  output logic [W-1:0] ed
);

  always_comb begin
    ed = (exact >= approx) ? (exact - approx) : (approx - exact);
  end

endmodule

// File: rtl/mul_err_monitor.sv
// Error statistics (sum/max/count of |a*b - approx|) over a window of samples.
// Optional MUL_ERR_SQ_EN adds an ED*ED sum output and one extra pipeline stage.
module mul_err_monitor
  import mul_err_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SAMPLES = DEF_SAMPLES,
  parameter int unsigned CNT_W   = cnt_width(SAMPLES),
  parameter int unsigned ACC_W   = acc_width(WIDTH, SAMPLES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   approx,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ack,
  output logic [ACC_W-1:0]     ed_sum,
  output logic [2*WIDTH-1:0]   ed_max,
`ifdef MUL_ERR_SQ_EN
  output logic [2*(2*WIDTH)+CNT_W-1:0] ed_sq_sum,
`endif
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int unsigned PW = 2 * WIDTH;

  state_t           state_q, state_d;
  logic             clr;
  logic             accept;
  logic             last;
  logic             pipe_busy;
  logic [CNT_W-1:0] acc_cnt_q;

  logic [PW-1:0]    s1_exact_q, s1_approx_q;
  logic             v1_q;
  logic [PW-1:0]    ed_c;
  logic [PW-1:0]    s2_ed_q;
  logic             v2_q;

  logic             acc_en;
  logic [PW-1:0]    acc_ed;
  logic [ACC_W-1:0] sum_q;
  logic [PW-1:0]    max_q;
  logic [CNT_W-1:0] cnt_q;

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q == ACCUM) || (state_q == DRAIN);
  assign res_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = accept && (acc_cnt_q == CNT_W'(SAMPLES - 1));

`ifdef MUL_ERR_SQ_EN
  localparam int unsigned SQ_W = 2 * PW + CNT_W;
  logic [PW-1:0]    s3_ed_q;
  logic [2*PW-1:0]  s3_sq_q;
  logic             v3_q;
  logic [SQ_W-1:0]  sq_q;

  assign pipe_busy = v1_q || v2_q || v3_q;
  assign acc_en    = v3_q;
  assign acc_ed    = s3_ed_q;
`else
  assign pipe_busy = v1_q || v2_q;
  assign acc_en    = v2_q;
  assign acc_ed    = s2_ed_q;
`endif

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          clr     = 1'b1;
        end
      end
      ACCUM: begin
        if (last) state_d = DRAIN;
      end
      DRAIN: begin
        if (!pipe_busy) state_d = DONE;
      end
      DONE: begin
        // start wins over res_ack so back-to-back windows need no idle cycle
        if (start) begin
          state_d = ACCUM;
          clr     = 1'b1;
        end else if (res_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (clr)         acc_cnt_q <= '0;
      else if (accept) acc_cnt_q <= acc_cnt_q + CNT_W'(1);
    end
  end

  err_dist #(.W(PW)) u_err_dist (
    .exact  (s1_exact_q),
    .approx (s1_approx_q),
    .ed     (ed_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
      v1_q        <= 1'b0;
      s2_ed_q     <= '0;
      v2_q        <= 1'b0;
    end else begin
      if (accept) begin
        s1_exact_q  <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        s1_approx_q <= approx;
      end
      s2_ed_q <= ed_c;
      if (clr) begin
        v1_q <= 1'b0;
        v2_q <= 1'b0;
      end else begin
        v1_q <= accept;
        v2_q <= v1_q;
      end
    end
  end

`ifdef MUL_ERR_SQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_ed_q <= '0;
      s3_sq_q <= '0;
      v3_q    <= 1'b0;
      sq_q    <= '0;
    end else begin
      s3_ed_q <= s2_ed_q;
      s3_sq_q <= {{PW{1'b0}}, s2_ed_q} * {{PW{1'b0}}, s2_ed_q};
      v3_q    <= clr ? 1'b0 : v2_q;
      if (clr)         sq_q <= '0;
      else if (acc_en) sq_q <= sq_q + SQ_W'(s3_sq_q);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else if (acc_en) begin
      sum_q <= sum_q + ACC_W'(acc_ed);
      if (acc_ed > max_q) max_q <= acc_ed;
      if (acc_ed != '0)   cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Result registers trail the accumulators by one edge; res_valid rises on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ed_sum  <= '0;
      ed_max  <= '0;
      err_cnt <= '0;
`ifdef MUL_ERR_SQ_EN
      ed_sq_sum <= '0;
`endif
    end else begin
      ed_sum  <= sum_q;
      ed_max  <= max_q;
      err_cnt <= cnt_q;
`ifdef MUL_ERR_SQ_EN
      ed_sq_sum <= sq_q;
`endif
    end
  end

endmodule

// File: tb/tb_mul_err_monitor.sv
// Randomized self-checking bench for mul_err_monitor against a window-level statistics model.
module tb_mul_err_monitor;

  localparam int unsigned W     = 6;
  localparam int unsigned S     = 4096;
  localparam int unsigned CW    = $clog2(S + 1);
  localparam int unsigned AW    = 2 * W + CW;
`ifdef MUL_ERR_SQ_EN
  localparam int unsigned LAT   = 4;
`else
  localparam int unsigned LAT   = 3;
`endif
  localparam int          LIMIT = 3 * S + 100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, in_valid, res_ack;
  logic              in_ready, busy, res_valid;
  logic [W-1:0]      a, b;
  logic [2*W-1:0]    approx;
  logic [AW-1:0]     ed_sum;
  logic [2*W-1:0]    ed_max;
  logic [CW-1:0]     err_cnt;
`ifdef MUL_ERR_SQ_EN
  logic [4*W+CW-1:0] ed_sq_sum;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  longint m_sum, m_max, m_cnt, m_sq;

  mul_err_monitor #(.WIDTH(W), .SAMPLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .approx    (approx),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ack   (res_ack),
    .ed_sum    (ed_sum),
    .ed_max    (ed_max),
`ifdef MUL_ERR_SQ_EN
    .ed_sq_sum (ed_sq_sum),
`endif
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_sum = 0; m_max = 0; m_cnt = 0; m_sq = 0;
  endtask

  task automatic model_add(input int ai, input int bi, input int api);
    longint p, e;
    p = longint'(ai) * longint'(bi);
    e = (p >= longint'(api)) ? p - longint'(api) : longint'(api) - p;
    m_sum += e;
    if (e > m_max) m_max = e;
    if (e != 0) m_cnt++;
    m_sq += e * e;
  endtask

  // kind 0: exhaustive exact sweep; kind 1: directed corner samples then random errors
  task automatic gen(input int kind, input int k, output int ga, output int gb, output int gap);
    int p, r;
    if (kind == 0) begin
      ga = k / 64; gb = k % 64; gap = ga * gb;
    end else if (k == 0) begin
      ga = 63; gb = 63; gap = 0;
    end else if (k == 1) begin
      ga = 2; gb = 3; gap = 10;
    end else if (k == 2) begin
      ga = 5; gb = 5; gap = 25;
    end else begin
      ga = int'($urandom_range(0, 63));
      gb = int'($urandom_range(0, 63));
      p  = ga * gb;
      r  = int'($urandom_range(0, 3));
      case (r)
        0:       gap = p;
        1:       gap = p - int'($urandom_range(0, p));
        2:       gap = p + int'($urandom_range(0, 4095 - p));
        default: gap = int'($urandom_range(0, 4095));
      endcase
    end
  endtask

  task automatic check_results(input string tag);
    check_eq({tag, "_ed_sum"},  ed_sum,  m_sum);
    check_eq({tag, "_ed_max"},  ed_max,  m_max);
    check_eq({tag, "_err_cnt"}, err_cnt, m_cnt);
`ifdef MUL_ERR_SQ_EN
    check_eq({tag, "_ed_sq_sum"}, ed_sq_sum, m_sq);
`endif
  endtask

  task automatic do_window(input string tag, input int kind, input bit gaps, input bit restart);
    int acc, edges, ga, gb, gap;
    acc = 0; edges = 0;
    model_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    if (restart) check_eq({tag, "_res_valid_drop"}, res_valid, 0);
    check_eq({tag, "_busy"}, busy, 1);
    while (acc < int'(S) && edges < LIMIT) begin
      gen(kind, acc, ga, gb, gap);
      a = W'(ga); b = W'(gb); approx = (2*W)'(gap);
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      check_eq({tag, "_in_ready"}, in_ready, 1);
      if (restart && edges == 1) begin
        check_eq({tag, "_cleared_sum"}, ed_sum, 0);
        check_eq({tag, "_cleared_max"}, ed_max, 0);
        check_eq({tag, "_cleared_cnt"}, err_cnt, 0);
      end
      if (in_valid) begin
        model_add(ga, gb, gap);
        acc++;
      end
      tick();
      edges++;
    end
    // Trailing valid sample that must not be taken.
    in_valid = 1'b1; a = '1; b = '1; approx = '0;
    while (res_valid !== 1'b1 && edges < LIMIT) begin
      check_eq({tag, "_in_ready_drain"}, in_ready, 0);
      tick();
      edges++;
    end
    if (res_valid !== 1'b1) check_eq({tag, "_res_valid_timeout"}, res_valid, 1);
    if (!gaps) check_eq({tag, "_latency"}, edges, S + LAT);
    check_eq({tag, "_in_ready_done"}, in_ready, 0);
    check_eq({tag, "_busy_done"}, busy, 0);
    check_results(tag);
    tick();
    check_eq({tag, "_hold_res_valid"}, res_valid, 1);
    check_results({tag, "_hold"});
    in_valid = 1'b0;
  endtask

  task automatic do_ack(input string tag);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    check_eq({tag, "_ack_res_valid"}, res_valid, 0);
    check_eq({tag, "_ack_in_ready"}, in_ready, 0);
    check_results({tag, "_ack"});
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    check_eq({tag, "_ack_idle_res_valid"}, res_valid, 0);
  endtask

  initial begin
    int ga, gb, gap;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; res_ack = 1'b0;
    a = '0; b = '0; approx = '0;
    model_clear();
    #12;
    check_eq("reset_in_ready", in_ready, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_res_valid", res_valid, 0);
    check_results("reset");
    #5 rst_n = 1'b1;
    tick();

    do_window("exact", 0, 1'b0, 1'b0);
    do_ack("exact");

    do_window("gaps", 1, 1'b1, 1'b0);
    do_ack("gaps");

    do_window("rand", 1, 1'b0, 1'b0);
    do_window("restart", 1, 1'b0, 1'b1);
    do_ack("restart");

    // Abort a window partway with an asynchronous reset.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      gen(1, i, ga, gb, gap);
      a = W'(ga); b = W'(gb); approx = (2*W)'(gap);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_eq("midrst_in_ready", in_ready, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_res_valid", res_valid, 0);
    check_results("midrst");
    #3 rst_n = 1'b1;
    tick();
    check_eq("midrst_idle_busy", busy, 0);
    do_window("postrst", 1, 1'b1, 1'b0);
    do_ack("postrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_err_monitor.md
Name: mul_err_monitor

Overview:
- Sits directly downstream of the approximate Dadda multiplier, next to an exact-product reference.
- Consumes a stream of operand pairs together with the approximate product the multiplier produced for them.
- Computes the error distance ED = |a*b - approx| and, over a window of SAMPLES accepted samples, accumulates the sum of ED, the maximum ED and the count of erroneous samples.
- Reports the results through a valid/ack handshake; these are the figures used to characterise each approximate multiplier variant.

Parameters:
- WIDTH, 6: operand width; products are 2*WIDTH bits.
- SAMPLES, 4096: samples per measurement window, range 1 .. 2**(2*WIDTH); the default is an exhaustive sweep for WIDTH=6.
- CNT_W, $clog2(SAMPLES+1): width of the sample and error counters.
- ACC_W, 2*WIDTH+CNT_W: width of the ED sum accumulator; it cannot overflow.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle pulse that begins a window; honoured only in IDLE or DONE.
- in_valid  in  1  a, b and approx are valid this cycle.
- in_ready  out  1  block accepts a sample this cycle.
- a  in  WIDTH  operand 1 (unsigned).
- b  in  WIDTH  operand 2 (unsigned).
- approx  in  2*WIDTH  product from the approximate multiplier for (a, b).
- busy  out  1  high in ACCUM and DRAIN.
- res_valid  out  1  results are valid and held stable.
- res_ack  in  1  consumer has taken the results.
- ed_sum  out  ACC_W  sum of ED over the window.
- ed_max  out  2*WIDTH  maximum ED over the window.
- err_cnt  out  CNT_W  number of samples with ED != 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all counters, accumulators and pipeline valids cleared.
  - in_ready=0, busy=0, res_valid=0, ed_sum=0, ed_max=0, err_cnt=0.
- FSM states (enum in package): IDLE, ACCUM, DRAIN, DONE.
  - IDLE, start=1 -> ACCUM: clear accumulators, accepted count and pipeline.
  - ACCUM: accept samples. The last accept (accepted reaches SAMPLES) -> DRAIN.
  - DRAIN: no accepts. When both pipeline valids are 0 -> DONE.
  - DONE: res_valid=1 and outputs frozen.
    - res_ack=1 -> IDLE; outputs keep their last values.
    - start=1 (with or without res_ack) -> ACCUM directly, accumulators cleared; start has priority.
- start in ACCUM or DRAIN is ignored. res_ack outside DONE is ignored.
- Handshake:
  - in_ready = (state==ACCUM); it is registered-state-derived, so there is no combinational path from in_valid.
  - A sample is accepted on a clock edge where in_valid && in_ready.
  - in_valid may drop at any time with no penalty. No bubbles are inserted by the block.
- Pipeline, 2 register stages:
  - S1 registers exact=a*b (2*WIDTH bits, behavioural multiply) and approx, with valid v1.
  - S2 registers ED = (exact>=approx) ? exact-approx : approx-exact, with valid v2.
  - Accumulate on v2:
    - ed_sum += ED.
    - ed_max = max(ed_max, ED).
    - err_cnt += (ED != 0).
  - A sample accepted at edge t is reflected in the outputs after edge t+3.
  - res_valid rises on the edge after the last accumulation.
- Arithmetic: all unsigned. ED is at most 2**(2*WIDTH)-1. ACC_W guarantees ed_sum never wraps, so no saturation logic is needed.
- Full throughput: one sample per cycle sustained; a SAMPLES window with continuous in_valid completes in SAMPLES+3 cycles after start.
- Reset mid-window: all progress is lost; results return to 0 and the state returns to IDLE.

Optional Feature:
- Macro MUL_ERR_SQ_EN.
- When defined:
  - Adds output ed_sq_sum [2*(2*WIDTH)+CNT_W-1:0], the sum of ED*ED.
  - An extra S3 squaring stage adds one cycle of latency (sample to output: t+4).
  - DRAIN also waits for v3.
  - ed_sq_sum is reset/cleared like ed_sum.
- When undefined: the port, the stage and the cycle are absent, and latency is as above.

Decomposition:
- Package mul_err_pkg holds:
  - the state_t enum (IDLE, ACCUM, DRAIN, DONE);
  - width helper functions for CNT_W and ACC_W;
  - the default WIDTH/SAMPLES constants.
- One sub-module, err_dist, is the natural split: a combinational |exact-approx| of 2*WIDTH bits. It is reused by other variant-characterisation benches.

Test Plan:
- Exhaustive exact: SAMPLES=4096, every (a,b) with approx=a*b, in_valid held -> ed_sum=0, ed_max=0, err_cnt=0; res_valid exactly 4099 cycles after start.
- Stuck-zero approx: SAMPLES=1, a=63, b=63, approx=0 -> ed_sum=3969, ed_max=3969, err_cnt=1.
- Overestimate: SAMPLES=2, samples (2,3,approx=10) and (5,5,approx=25) -> ed_sum=4, ed_max=4, err_cnt=1.
- Backpressure/gaps: SAMPLES=4, in_valid toggling 1,0,1,0,... -> exactly 4 samples accepted; in_ready=0 in DRAIN/DONE; extra in_valid afterwards is not consumed.
- Reset mid-window: assert rst_n=0 after 100 of 4096 samples -> all outputs 0 immediately (async), state IDLE; a new start then yields a correct full-window result.
- Restart from DONE: start while res_valid=1 without res_ack -> res_valid drops next cycle, accumulators cleared, new window accepted; with MUL_ERR_SQ_EN, the (63,63,0) sample gives ed_sq_sum=15752961.
